inv_mix_cols_seq: RTL
=====================

INV_MIX_COLS_SEQ -- requirements
Module: inv_mix_cols_seq

Interface
REQ-001 SHALL have parameter BYPASS_ROUND, default 4'd10, meaning the round_cnt value for which the block skips InvMixColumns (only when IMC_BYPASS_EN is defined).
REQ-002 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  state_in and round_cnt are valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a new state.
REQ-006 SHALL have port state_in  input  128  AES state; column c at bits [32c+31:32c]; row 0 is the MSB byte of each column.
REQ-007 SHALL have port round_cnt  input  4  decryption round number, sampled with state_in.
REQ-008 SHALL have port out_valid  output  1  state_out holds a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts state_out.
REQ-010 SHALL have port state_out  output  128  InvMixColumns result, same layout as state_in.
REQ-011 SHALL have port busy  output  1  high while columns are being computed.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready high in IDLE only, and out_valid high in DONE only.
REQ-014 SHALL, in IDLE on in_valid&&in_ready, register state_in and round_cnt, clear column counter col_idx to 0 and go to BUSY.
REQ-015 SHALL, in BUSY, compute one column per cycle in order col_idx 0,1,2,3, writing each result into its own 32-bit field of the result register; other fields keep their values.
REQ-016 SHALL compute column bytes a0..a3 as out_r = 0e*a_r ^ 0b*a_(r+1 mod 4) ^ 0d*a_(r+2 mod 4) ^ 09*a_(r+3 mod 4), using GF(2^8) with reduction polynomial 0x11b, built from a shared column datapath used once per cycle.
REQ-017 SHALL go from BUSY to DONE on the edge that writes column 3, wrapping col_idx to 0; latency is 4 cycles from the accept edge to out_valid high.
REQ-018 SHALL hold state_out and out_valid stable in DONE until out_ready is high, then go to IDLE on that edge (in_ready high in the next cycle; no same-cycle reaccept).
REQ-019 SHALL ignore in_valid, state_in and round_cnt changes while in BUSY or DONE.
REQ-020 SHALL drive busy = (state == BUSY).
REQ-021 SHALL treat out_ready asserted before DONE as no effect.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-computation, asynchronously force IDLE, col_idx=0, result register=128'h0, in_ready=1, out_valid=0 and busy=0.
REQ-023 SHALL discard any partial result on reset, with no output pulse after release.

Configuration
REQ-024 SHALL, with IMC_BYPASS_EN defined, go from IDLE directly to DONE with result=state_in when the accepted round_cnt==BYPASS_ROUND (out_valid one cycle after accept, busy never high).
REQ-025 SHALL, without IMC_BYPASS_EN, always apply InvMixColumns through BUSY regardless of round_cnt, and ignore BYPASS_ROUND.

Verification
REQ-026 SHALL cover this known-answer case: state_in=128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, round_cnt=1 -> after 4 cycles, out_valid=1 and state_out=128'hdb135345_f20a225c_d4d4d4d5_2d26314c.
REQ-027 SHALL cover this identity case: state_in=128'h01010101_c6c6c6c6_01010101_c6c6c6c6 -> state_out equals state_in after 4 cycles.
REQ-028 SHALL cover backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stay stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-029 SHALL cover reset mid-operation: rst_n low 2 cycles after accept -> immediately IDLE, state_out=0, out_valid=0; a fresh accept then yields a correct result.
REQ-030 SHALL cover bypass: with IMC_BYPASS_EN defined, round_cnt=10 and state_in=128'h0123456789abcdeffedcba9876543210 -> out_valid one cycle after accept with state_out unchanged; without the macro -> normal 4-cycle InvMixColumns result.
REQ-031 SHALL cover back-to-back operation: two vectors sent with in_valid held high and out_ready=1 -> each accepted only in IDLE, with both results correct and in order.

Source files
------------

// File: rtl/inv_mix_cols_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a shared datapath, valid/ready on both sides.
// Optional round bypass is compiled in with `define IMC_BYPASS_EN.
module inv_mix_cols_seq #(
  parameter logic [3:0] BYPASS_ROUND = 4'd10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [3:0]   round_cnt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for in_valid, in_ready high
  // BUSY  | computing column col_idx, one per cycle
  // DONE  | result held on state_out until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     col_idx;
  logic [127:0]   src_q;
  logic [127:0]   res_q;
  logic [31:0]    col_in;
  logic [31:0]    col_out;
  logic           accept;
  logic           bypass_hit;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  assign accept = in_valid && in_ready;

`ifdef IMC_BYPASS_EN
  // Decided from the live round_cnt on the accept edge, which is the sampled value.
  assign bypass_hit = (round_cnt == BYPASS_ROUND);
`else
  assign bypass_hit = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{round_cnt, BYPASS_ROUND};
`endif

  always_comb begin
    col_in = src_q[31:0];
    case (col_idx)
      2'd0: col_in = src_q[31:0];
      2'd1: col_in = src_q[63:32];
      2'd2: col_in = src_q[95:64];
      2'd3: col_in = src_q[127:96];
      default: col_in = src_q[31:0];
    endcase
  end

  // Row 0 is the MSB byte of the column.
  always_comb begin
    col_out[31:24] = m0e(col_in[31:24]) ^ m0b(col_in[23:16]) ^ m0d(col_in[15:8])   ^ m09(col_in[7:0]);
    col_out[23:16] = m0e(col_in[23:16]) ^ m0b(col_in[15:8])  ^ m0d(col_in[7:0])    ^ m09(col_in[31:24]);
    col_out[15:8]  = m0e(col_in[15:8])  ^ m0b(col_in[7:0])   ^ m0d(col_in[31:24])  ^ m09(col_in[23:16]);
    col_out[7:0]   = m0e(col_in[7:0])   ^ m0b(col_in[31:24]) ^ m0d(col_in[23:16])  ^ m09(col_in[15:8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_idx <= 2'd0;
      src_q   <= 128'h0;
      res_q   <= 128'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_q   <= state_in;
        col_idx <= 2'd0;
        if (bypass_hit) res_q <= state_in;
      end else if (state == BUSY) begin
        col_idx <= col_idx + 2'd1;
        case (col_idx)
          2'd0: res_q[31:0]   <= col_out;
          2'd1: res_q[63:32]  <= col_out;
          2'd2: res_q[95:64]  <= col_out;
          2'd3: res_q[127:96] <= col_out;
          default: res_q <= res_q;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = bypass_hit ? DONE : BUSY;
      BUSY: if (col_idx == 2'd3) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign state_out = res_q;

endmodule
